// File: rtl/fetch_control_unit_pkg.sv
// Shared definitions for the instruction-fetch controller: PC source
// encodings (common with the datapath) and the fetch FSM state encoding.
package fetch_control_unit_pkg;

  localparam logic [1:0] PC_SRC_NEXT   = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_FAULT = 2'b11
  } fetch_state_t;

  // A trap always wins over a branch redirect arriving in the same cycle.
  function automatic logic [1:0] redirect_src(input logic trap, input logic redirect);
    redirect_src = trap ? PC_SRC_TRAP : (redirect ? PC_SRC_BRANCH : PC_SRC_NEXT);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles spent waiting for instruction memory; flags expiry one
// cycle before the configured limit so the FSM can leave FETCH on time.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TIMEOUT_WIDTH-1:0] LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/fetch_control_unit.sv
// Instruction-fetch sequencer: memory request/ack handshake, PC/IR load
// strobes, and absorption of redirects and traps during an in-flight fetch.
module fetch_control_unit
  import fetch_control_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic       fetch_ctrl_clock_in,
  input  logic       fetch_ctrl_reset_in,
  input  logic       fetch_ctrl_enable_in,
  input  logic       fetch_ctrl_mem_ack_in,
  input  logic       fetch_ctrl_mem_err_in,
  input  logic       fetch_ctrl_redirect_in,
  input  logic       fetch_ctrl_trap_in,
  input  logic       fetch_ctrl_decode_rdy_in,
  output logic       fetch_ctrl_mem_req_out,
  output logic       fetch_ctrl_pc_set_out,
  output logic [1:0] fetch_ctrl_pc_src_out,
  output logic       fetch_ctrl_ir_set_out,
  output logic       fetch_ctrl_ir_valid_out,
  output logic       fetch_ctrl_fault_out
);

  fetch_state_t state, state_next;
  logic         pend_vld, pend_vld_next;
  logic [1:0]   pend_src, pend_src_next;
  logic         pc_set, ir_set;
  logic [1:0]   pc_src;
  logic         expired, count_en, clear;
  logic         flush;

  assign flush    = fetch_ctrl_trap_in | fetch_ctrl_redirect_in;
  assign count_en = (state == ST_FETCH) & ~fetch_ctrl_mem_ack_in;
  assign clear    = (state != ST_FETCH) | fetch_ctrl_mem_ack_in | expired;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk     (fetch_ctrl_clock_in),
    .rst_n   (fetch_ctrl_reset_in),
    .clear   (clear),
    .count_en(count_en),
    .expired (expired)
  );

  always_comb begin
    state_next    = state;
    pc_set        = 1'b0;
    pc_src        = PC_SRC_NEXT;
    ir_set        = 1'b0;
    pend_vld_next = 1'b0;
    pend_src_next = pend_src;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          pc_set = 1'b1;
          pc_src = redirect_src(fetch_ctrl_trap_in, fetch_ctrl_redirect_in);
        end
        if (fetch_ctrl_enable_in) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        pend_vld_next = pend_vld;
        if (fetch_ctrl_mem_ack_in) begin
          pend_vld_next = 1'b0;
          if (fetch_ctrl_mem_err_in) begin
            state_next = ST_FAULT;
          end else if (flush || pend_vld) begin
            // Returned word belongs to the abandoned path: drop it, retarget PC.
            pc_set     = 1'b1;
            pc_src     = flush ? redirect_src(fetch_ctrl_trap_in, fetch_ctrl_redirect_in)
                               : pend_src;
            state_next = fetch_ctrl_enable_in ? ST_FETCH : ST_IDLE;
          end else begin
            ir_set     = 1'b1;
            pc_set     = 1'b1;
            state_next = ST_HOLD;
          end
        end else if (expired) begin
          pend_vld_next = 1'b0;
          state_next    = ST_FAULT;
        end else if (fetch_ctrl_trap_in) begin
          pend_vld_next = 1'b1;
          pend_src_next = PC_SRC_TRAP;
        end else if (fetch_ctrl_redirect_in && !(pend_vld && pend_src == PC_SRC_TRAP)) begin
          pend_vld_next = 1'b1;
          pend_src_next = PC_SRC_BRANCH;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          pc_set     = 1'b1;
          pc_src     = redirect_src(fetch_ctrl_trap_in, fetch_ctrl_redirect_in);
          state_next = fetch_ctrl_enable_in ? ST_FETCH : ST_IDLE;
        end else if (fetch_ctrl_decode_rdy_in) begin
          state_next = fetch_ctrl_enable_in ? ST_FETCH : ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fetch_ctrl_trap_in) begin
          pc_set     = 1'b1;
          pc_src     = PC_SRC_TRAP;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge fetch_ctrl_clock_in or negedge fetch_ctrl_reset_in) begin
    if (!fetch_ctrl_reset_in) begin
      state                   <= ST_IDLE;
      pend_vld                <= 1'b0;
      pend_src                <= PC_SRC_NEXT;
      fetch_ctrl_mem_req_out  <= 1'b0;
      fetch_ctrl_ir_valid_out <= 1'b0;
      fetch_ctrl_fault_out    <= 1'b0;
    end else begin
      state                   <= state_next;
      pend_vld                <= pend_vld_next;
      pend_src                <= pend_src_next;
      fetch_ctrl_mem_req_out  <= (state_next == ST_FETCH);
      fetch_ctrl_ir_valid_out <= (state_next == ST_HOLD);
      fetch_ctrl_fault_out    <= (state_next == ST_FAULT);
    end
  end

  // Strobes are forced low while reset is held so every output reads 0 in reset.
  assign fetch_ctrl_pc_set_out = pc_set & fetch_ctrl_reset_in;
  assign fetch_ctrl_pc_src_out = (pc_set & fetch_ctrl_reset_in) ? pc_src : PC_SRC_NEXT;
  assign fetch_ctrl_ir_set_out = ir_set & fetch_ctrl_reset_in;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit; per-cycle expectations flow through
// a scoreboard queue to an independent negedge monitor.
module tb_fetch_control_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, ack = 1'b0, err = 1'b0, redir = 1'b0, trap = 1'b0, drdy = 1'b0;
  logic       mem_req, pc_set, ir_set, ir_valid, fault;
  logic [1:0] pc_src;

  typedef struct {
    logic [6:0] ex;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  fetch_control_unit #(.TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5)) dut (
    .fetch_ctrl_clock_in     (clk),
    .fetch_ctrl_reset_in     (rst_n),
    .fetch_ctrl_enable_in    (en),
    .fetch_ctrl_mem_ack_in   (ack),
    .fetch_ctrl_mem_err_in   (err),
    .fetch_ctrl_redirect_in  (redir),
    .fetch_ctrl_trap_in      (trap),
    .fetch_ctrl_decode_rdy_in(drdy),
    .fetch_ctrl_mem_req_out  (mem_req),
    .fetch_ctrl_pc_set_out   (pc_set),
    .fetch_ctrl_pc_src_out   (pc_src),
    .fetch_ctrl_ir_set_out   (ir_set),
    .fetch_ctrl_ir_valid_out (ir_valid),
    .fetch_ctrl_fault_out    (fault)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // in  = {en, ack, err, redirect, trap, decode_rdy}
  // ex  = {mem_req, pc_set, pc_src[1:0], ir_set, ir_valid, fault}
  task automatic cyc(input logic rst, input logic [5:0] in, input logic [6:0] ex, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    {en, ack, err, redir, trap, drdy} = in;
    e.ex = ex;
    e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    exp_t       e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {mem_req, pc_set, pc_src, ir_set, ir_valid, fault};
        total++;
        if (act !== e.ex) begin
          bad++;
          $display("FAIL %s: got req/pcset/src/irset/irvalid/fault=%b required %b", e.nm, act, e.ex);
        end
      end
    end
  end

  initial begin
    // reset, then start fetching
    cyc(1'b0, 6'b000000, 7'b0000000, "reset0");
    cyc(1'b0, 6'b000000, 7'b0000000, "reset1");
    cyc(1'b1, 6'b100000, 7'b0000000, "idle_enable");
    // plain fetch, ack after two wait cycles
    cyc(1'b1, 6'b100000, 7'b1000000, "t1_req1");
    cyc(1'b1, 6'b100000, 7'b1000000, "t1_req2");
    cyc(1'b1, 6'b110000, 7'b1100100, "t1_ack");
    cyc(1'b1, 6'b100000, 7'b0000010, "t1_hold");
    cyc(1'b1, 6'b100001, 7'b0000010, "t1_consume");
    // redirect during fetch, resolved at ack
    cyc(1'b1, 6'b100000, 7'b1000000, "t2_req");
    cyc(1'b1, 6'b100100, 7'b1000000, "t2_redir");
    cyc(1'b1, 6'b100000, 7'b1000000, "t2_wait");
    cyc(1'b1, 6'b110000, 7'b1101000, "t2_ack");
    // trap overrides pending redirect; later redirect cannot displace it
    cyc(1'b1, 6'b100100, 7'b1000000, "t3_redir");
    cyc(1'b1, 6'b100010, 7'b1000000, "t3_trap");
    cyc(1'b1, 6'b100100, 7'b1000000, "t3_redir2");
    cyc(1'b1, 6'b010000, 7'b1110000, "t3_ack");
    cyc(1'b1, 6'b100000, 7'b0000000, "t3_idle");
    cyc(1'b1, 6'b110000, 7'b1100100, "t3_clean_fetch");
    cyc(1'b1, 6'b000001, 7'b0000010, "t3_hold_stop");
    cyc(1'b1, 6'b000000, 7'b0000000, "t3_idle_stop");
    // redirect/trap while idle
    cyc(1'b1, 6'b000100, 7'b0101000, "idle_redir");
    cyc(1'b1, 6'b000110, 7'b0110000, "idle_trap");
    // timeout after 16 fetch cycles without ack
    cyc(1'b1, 6'b100000, 7'b0000000, "t4_start");
    for (int i = 0; i < 16; i++) cyc(1'b1, 6'b100000, 7'b1000000, $sformatf("t4_wait%0d", i));
    cyc(1'b1, 6'b110100, 7'b0000001, "t4_late_ack");
    cyc(1'b1, 6'b000000, 7'b0000001, "t4_fault");
    cyc(1'b1, 6'b100010, 7'b0110001, "t4_trap");
    cyc(1'b1, 6'b110000, 7'b1100100, "t4_refetch");
    // HOLD: redirect beats decode_rdy
    cyc(1'b1, 6'b100101, 7'b0101010, "t6_hold_redir");
    // bus error on ack
    cyc(1'b1, 6'b111000, 7'b1000000, "t5_ack_err");
    cyc(1'b1, 6'b100000, 7'b0000001, "t5_fault");
    cyc(1'b1, 6'b100010, 7'b0110001, "t5_trap");
    // asynchronous reset mid-fetch
    cyc(1'b1, 6'b100000, 7'b1000000, "t7_fetch");
    cyc(1'b0, 6'b100100, 7'b0000000, "t7_async_reset");
    cyc(1'b0, 6'b000000, 7'b0000000, "t7_reset_hold");
    cyc(1'b1, 6'b000000, 7'b0000000, "t7_idle");

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
